// File: rtl/spi_i2s_tx_shift.sv
// Serial transmit shifter for the SPI/I2S block: pulls 16-bit words from the TX FIFO
// and shifts them out MSB first, one bit per shift_stb, padding each slot with zeros.
module spi_i2s_tx_shift (
  input  logic        pclk,
  input  logic        rst,
  input  logic        shft_en,
  input  logic        shift_stb,
  input  logic [1:0]  datlen,
  input  logic        chlen,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_rdata,
  output logic        fifo_rd,
  output logic        sd_out,
  output logic        tx_shift_empty,
  output logic        udr,
  output logic        slot_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, PAD} state_t;

  state_t      r_state;
  logic [15:0] r_shreg;
  logic [4:0]  r_slotCnt;
  logic        r_udrPad;
  logic        r_fifoRd;
  logic        r_sdOut;
  logic        r_txEmpty;
  logic        r_udr;
  logic        r_slotDone;

  logic [4:0]  w_dataLast;
  logic [4:0]  w_slotLast;
  logic        w_dataEqSlot;
  logic        w_canFetch;

  // Index of the last data bit and the last slot bit; wide data forces a 32-bit slot.
  always_comb begin
    w_dataLast = 5'd15;
    case (datlen)
      2'b01:   w_dataLast = 5'd23;
      2'b10:   w_dataLast = 5'd31;
      default: w_dataLast = 5'd15;
    endcase
  end

  assign w_slotLast   = (chlen || (w_dataLast != 5'd15)) ? 5'd31 : 5'd15;
  assign w_dataEqSlot = (w_dataLast == w_slotLast);
  assign w_canFetch   = shft_en && !fifo_empty;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= 16'h0000;
      r_slotCnt  <= 5'd0;
      r_udrPad   <= 1'b0;
      r_fifoRd   <= 1'b0;
      r_sdOut    <= 1'b0;
      r_txEmpty  <= 1'b1;
      r_udr      <= 1'b0;
      r_slotDone <= 1'b0;
    end else begin
      r_fifoRd   <= 1'b0;
      r_udr      <= 1'b0;
      r_slotDone <= 1'b0;
      case (r_state)
        IDLE: begin
          r_txEmpty <= 1'b1;
          if (w_canFetch) begin
            r_state   <= FETCH;
            r_fifoRd  <= 1'b1;
            r_slotCnt <= 5'd0;
            r_udrPad  <= 1'b0;
            r_txEmpty <= 1'b0;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_shreg <= fifo_rdata;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (shift_stb) begin
            r_sdOut   <= r_shreg[15];
            r_shreg   <= {r_shreg[14:0], 1'b0};
            r_slotCnt <= r_slotCnt + 5'd1;
            if (r_slotCnt == w_dataLast) begin
              if (w_dataEqSlot) begin
                r_slotDone <= 1'b1;
                if (w_canFetch) begin
                  r_state   <= FETCH;
                  r_fifoRd  <= 1'b1;
                  r_slotCnt <= 5'd0;
                end else begin
                  r_state   <= IDLE;
                  r_txEmpty <= 1'b1;
                end
              end else begin
                r_state <= PAD;
              end
            end else if (r_slotCnt[3:0] == 4'hF) begin
              // Mid-slot word boundary: the slot needs another word regardless of shft_en.
              if (!fifo_empty) begin
                r_state  <= FETCH;
                r_fifoRd <= 1'b1;
              end else begin
                r_udr     <= 1'b1;
                r_udrPad  <= 1'b1;
                r_txEmpty <= 1'b1;
                r_state   <= PAD;
              end
            end
          end
        end
        PAD: begin
          if (shift_stb) begin
            r_sdOut   <= 1'b0;
            r_slotCnt <= r_slotCnt + 5'd1;
            if (r_slotCnt == w_slotLast) begin
              r_slotDone <= 1'b1;
              if (!r_udrPad && w_canFetch) begin
                r_state   <= FETCH;
                r_fifoRd  <= 1'b1;
                r_slotCnt <= 5'd0;
              end else begin
                r_state   <= IDLE;
                r_txEmpty <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_txEmpty <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_rd        = r_fifoRd;
  assign sd_out         = r_sdOut;
  assign tx_shift_empty = r_txEmpty;
  assign udr            = r_udr;
  assign slot_done      = r_slotDone;

endmodule

// File: tb/tb_spi_i2s_tx_shift.sv
// Directed bench for spi_i2s_tx_shift: a small FIFO model feeds words, and a scoreboard
// of expected serial bits / slot_done / udr is popped on every shift strobe.
module tb_spi_i2s_tx_shift;

  logic        pclk = 1'b0;
  logic        rst;
  logic        shft_en;
  logic        shift_stb;
  logic [1:0]  datlen;
  logic        chlen;
  logic        fifo_empty;
  logic [15:0] fifo_rdata = 16'h0000;
  logic        fifo_rd;
  logic        sd_out;
  logic        tx_shift_empty;
  logic        udr;
  logic        slot_done;

  typedef struct packed {
    logic sd;
    logic done;
    logic u;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] wordMem [0:31];
  logic [4:0]  wrPtr = 5'd0;
  logic [4:0]  rdPtr = 5'd0;
  int          rdCount   = 0;
  int          rdOnEmpty = 0;
  int          udrCount  = 0;
  int          doneCount = 0;
  int          errors    = 0;
  int          checks    = 0;
  int          r0, d0, u0;

  spi_i2s_tx_shift dut (
    .pclk           (pclk),
    .rst            (rst),
    .shft_en        (shft_en),
    .shift_stb      (shift_stb),
    .datlen         (datlen),
    .chlen          (chlen),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd        (fifo_rd),
    .sd_out         (sd_out),
    .tx_shift_empty (tx_shift_empty),
    .udr            (udr),
    .slot_done      (slot_done)
  );

  always #5 pclk = ~pclk;

  assign fifo_empty = (wrPtr == rdPtr);

  // FIFO model: data appears on fifo_rdata the cycle after the pop request.
  always @(posedge pclk) begin
    if (fifo_rd) begin
      if (wrPtr == rdPtr) rdOnEmpty <= rdOnEmpty + 1;
      fifo_rdata <= wordMem[rdPtr];
      rdPtr      <= rdPtr + 5'd1;
      rdCount    <= rdCount + 1;
    end
    if (udr)       udrCount  <= udrCount + 1;
    if (slot_done) doneCount <= doneCount + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task tick;
    @(posedge pclk);
    #1;
  endtask

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task pushWord(input logic [15:0] w);
    wordMem[wrPtr] = w;
    wrPtr = wrPtr + 5'd1;
  endtask

  // Queue the first n bits of a left-justified pattern; doneAt/udrAt are 1-based strobe numbers.
  task pushBits(input logic [31:0] pat, input int n, input int doneAt, input int udrAt);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sd   = pat[31-i];
      e.done = (i == doneAt - 1);
      e.u    = (i == udrAt - 1);
      expQ.push_back(e);
    end
  endtask

  // Issue n strobes four pclk apart and compare each resulting bit against the scoreboard.
  task applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      shift_stb = 1'b1;
      tick();
      shift_stb = 1'b0;
      checkOutput("sbDepth", (expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("sdOut[%0d]", i), sd_out, e.sd);
        checkOutput($sformatf("slotDone[%0d]", i), slot_done, e.done);
        checkOutput($sformatf("udr[%0d]", i), udr, e.u);
      end
      repeat (3) tick();
    end
  endtask

  task startStream;
    r0 = rdCount;
    d0 = doneCount;
    u0 = udrCount;
    shft_en = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst       = 1'b1;
    shft_en   = 1'b0;
    shift_stb = 1'b0;
    datlen    = 2'b00;
    chlen     = 1'b0;
    repeat (3) tick();
    checkOutput("rstSdOut", sd_out, 0);
    checkOutput("rstFifoRd", fifo_rd, 0);
    checkOutput("rstUdr", udr, 0);
    checkOutput("rstSlotDone", slot_done, 0);
    checkOutput("rstTxEmpty", tx_shift_empty, 1);
    rst = 1'b0;
    tick();

    $display("[TB] 16/16 single word");
    pushWord(16'hA5C3);
    pushBits(32'hA5C3_0000, 16, 16, 0);
    startStream();
    applyStimulus(16);
    checkOutput("s1Empty", tx_shift_empty, 1);
    shft_en = 1'b0;
    repeat (4) tick();
    checkOutput("s1Reads", rdCount - r0, 1);
    checkOutput("s1Done", doneCount - d0, 1);

    $display("[TB] 24-bit data in 32-bit slot");
    datlen = 2'b01;
    pushWord(16'h1234);
    pushWord(16'hAB00);
    pushBits(32'h1234_AB00, 32, 32, 0);
    startStream();
    applyStimulus(16);
    checkOutput("s2Busy", tx_shift_empty, 0);
    applyStimulus(16);
    shft_en = 1'b0;
    repeat (4) tick();
    checkOutput("s2Reads", rdCount - r0, 2);
    checkOutput("s2Done", doneCount - d0, 1);
    checkOutput("s2Empty", tx_shift_empty, 1);

    $display("[TB] 32-bit data with underrun");
    datlen = 2'b10;
    pushWord(16'hFFFF);
    pushBits(32'hFFFF_0000, 32, 32, 16);
    startStream();
    applyStimulus(16);
    checkOutput("s3UdrCount", udrCount - u0, 1);
    checkOutput("s3UdrPadEmpty", tx_shift_empty, 1);
    applyStimulus(16);
    shft_en = 1'b0;
    repeat (4) tick();
    checkOutput("s3Reads", rdCount - r0, 1);
    checkOutput("s3UdrTotal", udrCount - u0, 1);
    checkOutput("s3Empty", tx_shift_empty, 1);

    $display("[TB] 16-bit data in 32-bit slots back to back");
    datlen = 2'b00;
    chlen  = 1'b1;
    pushWord(16'h8001);
    pushWord(16'h0001);
    pushBits(32'h8001_0000, 32, 32, 0);
    pushBits(32'h0001_0000, 32, 32, 0);
    startStream();
    applyStimulus(64);
    shft_en = 1'b0;
    repeat (4) tick();
    checkOutput("s4Reads", rdCount - r0, 2);
    checkOutput("s4Done", doneCount - d0, 2);
    checkOutput("s4Empty", tx_shift_empty, 1);

    $display("[TB] shft_en dropped mid-slot");
    chlen = 1'b0;
    pushWord(16'h3C5A);
    pushWord(16'h7777);
    pushBits(32'h3C5A_0000, 16, 16, 0);
    startStream();
    applyStimulus(5);
    shft_en = 1'b0;
    applyStimulus(11);
    repeat (4) tick();
    checkOutput("s5Reads", rdCount - r0, 1);
    checkOutput("s5Done", doneCount - d0, 1);
    checkOutput("s5Empty", tx_shift_empty, 1);
    checkOutput("s5Left", 32'(wrPtr - rdPtr), 1);

    $display("[TB] reset mid-slot");
    pushWord(16'h9999);
    pushBits(32'h7777_0000, 10, 0, 0);
    startStream();
    applyStimulus(10);
    rst     = 1'b1;
    shft_en = 1'b0;
    tick();
    checkOutput("s6SdOut", sd_out, 0);
    checkOutput("s6Empty", tx_shift_empty, 1);
    rst = 1'b0;
    repeat (6) tick();
    checkOutput("s6Reads", rdCount - r0, 1);
    checkOutput("s6Left", 32'(wrPtr - rdPtr), 1);
    checkOutput("s6Udr", udrCount - u0, 0);
    checkOutput("s6Done", doneCount - d0, 0);

    checkOutput("sbDrained", expQ.size(), 0);
    checkOutput("rdOnEmpty", rdOnEmpty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
